// File: rtl/control_unit.sv
// Registered opcode decoder: turns the instruction's opcode field into the
// register-file write enable, the ALU add/subtract select and an illegal-opcode flag.
module control_unit #(
  parameter int              OP_W   = 7,
  parameter logic [OP_W-1:0] OP_NOP = 7'h00,
  parameter logic [OP_W-1:0] OP_ADD = 7'h01,
  parameter logic [OP_W-1:0] OP_SUB = 7'h02
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] op_code,
  input  logic            op_valid,
  output logic            wr_en,
  output logic            alu_op,
  output logic            illegal
);

  logic wr_en_q, wr_en_d;
  logic alu_op_q, alu_op_d;
  logic illegal_q, illegal_d;

  // Idle cycles keep the last ALU select so the datapath mux does not toggle.
  always_comb begin
    wr_en_d   = 1'b0;
    illegal_d = 1'b0;
    alu_op_d  = alu_op_q;
    if (op_valid) begin
      if (op_code == OP_NOP) begin
        alu_op_d = 1'b0;
      end else if (op_code == OP_ADD) begin
        wr_en_d  = 1'b1;
        alu_op_d = 1'b0;
      end else if (op_code == OP_SUB) begin
        wr_en_d  = 1'b1;
        alu_op_d = 1'b1;
      end else begin
        alu_op_d  = 1'b0;
        illegal_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      alu_op_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      wr_en_q   <= wr_en_d;
      alu_op_q  <= alu_op_d;
      illegal_q <= illegal_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign alu_op  = alu_op_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: a driver queues the reference-model response per
// cycle, a monitor pops and compares it one clock after each sampling edge.
module tb_control_unit;
  localparam int OP_W = 7;

  logic            clk      = 1'b0;
  logic            rst_n    = 1'b0;
  logic [OP_W-1:0] op_code  = '0;
  logic            op_valid = 1'b0;
  logic            wr_en, alu_op, illegal;

  always #5 clk = ~clk;

  control_unit #(.OP_W(OP_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op_code  (op_code),
    .op_valid (op_valid),
    .wr_en    (wr_en),
    .alu_op   (alu_op),
    .illegal  (illegal)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [2:0]  exp_q[$];
  string       tag_q[$];
  logic        m_alu = 1'b0;

  // Reference model: expected {wr_en, alu_op, illegal} for the cycle driven here.
  task automatic issue(input logic rst, input logic v, input logic [OP_W-1:0] code,
                       input bit xcode, input string tag);
    logic [2:0] e;
    @(negedge clk);
    rst_n    = rst;
    op_valid = v;
    if (xcode) op_code = 'x;
    else       op_code = code;
    if (!rst) begin
      m_alu = 1'b0;
      e     = 3'b000;
    end else if (!v) begin
      e = {1'b0, m_alu, 1'b0};
    end else if (code == 7'h00) begin
      m_alu = 1'b0;
      e     = 3'b000;
    end else if (code == 7'h01) begin
      m_alu = 1'b0;
      e     = 3'b100;
    end else if (code == 7'h02) begin
      m_alu = 1'b1;
      e     = 3'b110;
    end else begin
      m_alu = 1'b0;
      e     = 3'b001;
    end
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  always @(posedge clk) begin
    logic [2:0] e;
    string      t;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      n_checks++;
      if ({wr_en, alu_op, illegal} !== e) begin
        n_fail++;
        $display("FAIL %s: wr_en/alu_op/illegal got %b required %b at %0t",
                 t, {wr_en, alu_op, illegal}, e, $time);
      end
      n_checks++;
      if (wr_en === 1'b1 && illegal === 1'b1) begin
        n_fail++;
        $display("FAIL %s_excl: wr_en and illegal both 1, required not both", t);
      end
    end
  end

  initial begin
    logic       v;
    logic [6:0] code;
    logic       r;
    bit         drained;

    repeat (3) issue(1'b0, 1'b1, 7'h01, 1'b0, "reset_hold");

    issue(1'b1, 1'b1, 7'h01, 1'b0, "add_r1_r0");
    issue(1'b1, 1'b1, 7'h01, 1'b0, "add_r4_r2");
    issue(1'b1, 1'b1, 7'h01, 1'b0, "add_r2_r1");
    issue(1'b1, 1'b1, 7'h00, 1'b0, "nop_after_add");

    issue(1'b1, 1'b1, 7'h02, 1'b0, "sub");
    issue(1'b1, 1'b0, 7'h02, 1'b0, "idle_hold1");
    issue(1'b1, 1'b0, 7'h02, 1'b0, "idle_hold2");

    issue(1'b1, 1'b1, 7'h03, 1'b0, "illegal_03");
    issue(1'b1, 1'b1, 7'h40, 1'b0, "illegal_40");
    issue(1'b1, 1'b1, 7'h7F, 1'b0, "illegal_7f");
    issue(1'b1, 1'b1, 7'h01, 1'b0, "add_clears_illegal");

    issue(1'b1, 1'b1, 7'h02, 1'b0, "sub_before_idle");
    issue(1'b1, 1'b0, 7'h01, 1'b0, "invalid_add_ignored");
    issue(1'b1, 1'b0, 7'h00, 1'b1, "invalid_x_ignored");
    @(posedge clk);
    #2;
    n_checks++;
    if ($isunknown({wr_en, alu_op, illegal})) begin
      n_fail++;
      $display("FAIL no_x_out: outputs got %b required no X", {wr_en, alu_op, illegal});
    end

    for (int i = 0; i < 16; i++)
      issue(1'b1, 1'b1, (i % 2 == 0) ? 7'h01 : 7'h02, 1'b0, "alternate_add_sub");

    // Asynchronous reset in the middle of a cycle after an ADD.
    issue(1'b1, 1'b1, 7'h01, 1'b0, "add_before_async_rst");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    m_alu = 1'b0;
    #1;
    n_checks++;
    if ({wr_en, alu_op, illegal} !== 3'b000) begin
      n_fail++;
      $display("FAIL async_reset: outputs got %b required 000", {wr_en, alu_op, illegal});
    end
    issue(1'b0, 1'b1, 7'h02, 1'b0, "reset_discards_sub");
    issue(1'b1, 1'b1, 7'h02, 1'b0, "first_after_release");

    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(0, 31) != 0);
      v = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       code = 7'h00;
        1:       code = 7'h01;
        2:       code = 7'h02;
        default: code = 7'($urandom_range(0, 127));
      endcase
      issue(r, v, code, 1'b0, "random");
    end

    drained = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        drained = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!drained) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Registered instruction-decode control unit for the small register-file datapath.
- Takes the 7-bit opcode field (bits [15:9] of the 16-bit instruction word) and produces the register-file write enable and the ALU operation select for the execute stage.
- Also flags unsupported opcodes.
- Sits between instruction fetch/field split and the register file / ALU.

Parameters:
- OP_W, 7, opcode field width; the decode table below is defined for OP_W = 7 only.
- OP_NOP, 7'h00, opcode for no-operation.
- OP_ADD, 7'h01, opcode for r[rd] <= r[rs1] + r[rs2].
- OP_SUB, 7'h02, opcode for r[rd] <= r[rs1] - r[rs2].

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- op_code  input  OP_W  opcode field of the current instruction.
- op_valid  input  1  op_code is valid this cycle and is decoded.
- wr_en  output  1  register-file write enable for the decoded instruction.
- alu_op  output  1  ALU operation select: 0 = add, 1 = subtract.
- illegal  output  1  decoded opcode is not in the supported set.

Behaviour:
- Reset, asynchronous on rst_n low, immediate and independent of clk:
  - wr_en = 0, alu_op = 0, illegal = 0.
  - Outputs stay there while rst_n is low.
  - Release is synchronous: the first decode happens on the first rising edge with rst_n high.
- Latency: all outputs are registered. op_code/op_valid sampled at edge N appear on the outputs after edge N and hold until edge N+1. There are no combinational paths from inputs to outputs.
- Decode when op_valid = 1 at the sampling edge:
  - OP_NOP (7'h00): wr_en = 0, alu_op = 0, illegal = 0.
  - OP_ADD (7'h01): wr_en = 1, alu_op = 0, illegal = 0.
  - OP_SUB (7'h02): wr_en = 1, alu_op = 1, illegal = 0.
  - Any other value: wr_en = 0, alu_op = 0, illegal = 1. An illegal opcode never writes the register file.
- When op_valid = 0 at the sampling edge:
  - wr_en = 0 and illegal = 0.
  - alu_op holds its previous value, so the ALU select does not toggle on idle cycles.
  - op_code is ignored, including X/Z values.
- Back-to-back instructions: every cycle with op_valid = 1 is decoded independently. No internal state other than the output registers; no stall or handshake back-pressure.
- Reset mid-stream: an instruction sampled on the edge coinciding with rst_n low is discarded. Outputs return to their reset values immediately.
- wr_en is never asserted in the same cycle as illegal.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with op_valid = 1, op_code = 7'h01 -> wr_en = 0, alu_op = 0, illegal = 0 throughout. Assert rst_n low mid-cycle after an ADD -> outputs drop to 0 before the next edge.
- ADD sequence: op_valid = 1 with op_code 7'h01 three consecutive cycles (instructions r1+r0->r0, r4+r2->r4, r2+r1->r1), then 7'h00 -> wr_en = 1, alu_op = 0 for three cycles, each one cycle after its sample. Then wr_en = 0, illegal = 0 for the NOP.
- SUB then idle: 7'h02 valid, then op_valid = 0 for two cycles -> wr_en 1 then 0, 0; alu_op 1, 1, 1 (held); illegal 0 throughout.
- Illegal opcodes: 7'h03, 7'h40, 7'h7F each with op_valid = 1 -> illegal = 1, wr_en = 0, alu_op = 0 one cycle later. A following 7'h01 clears illegal and sets wr_en = 1.
- Invalid input ignored: op_valid = 0 with op_code = 7'h01 and then X -> wr_en = 0, illegal = 0, alu_op unchanged, no X on any output.
- Alternating ADD/SUB every cycle for 16 cycles -> alu_op toggles 0/1 each cycle with exactly one cycle of latency, and wr_en stays 1.
